// File: rtl/tqvp_uart_fifo.sv
// rtl/tqvp_uart_fifo.sv - buffered TinyQV UART with TX/RX FIFOs, parity and sticky flags
// Optional parity generation/checking is built only when UART_PARITY_EN is defined.

module tqvp_uart_fifo_q #(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [7:0]                push_data,
    input  logic                      pop,
    output logic [7:0]                head,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

module tqvp_uart_fifo #(
    parameter int DIVIDER_REG_LEN = 13,
    parameter int CLOCK_MHZ       = 64,
    parameter int TX_DEPTH        = 4,
    parameter int RX_DEPTH        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic [1:0]  user_interrupt
);
    localparam int DW  = DIVIDER_REG_LEN;
    localparam int TLW = $clog2(TX_DEPTH) + 1;
    localparam int RLW = $clog2(RX_DEPTH) + 1;
    localparam logic [DW-1:0] DIV_RESET = DW'(CLOCK_MHZ * 1000000 / 115200);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic          wr, rd;
    logic [DW-1:0] divider, div_eff, bit_len, half_len;
    logic [7:0]    ctrl;
    logic [3:0]    flags, flag_set, flag_clr;
    logic          par_en, par_odd;
    logic [3:0]    rx_thr;
    logic          rts, txd, rxd, rxd_q;

    logic [7:0]     tx_head, rx_head;
    logic [TLW-1:0] tx_level;
    logic [RLW-1:0] rx_level;
    logic           tx_full, tx_empty, rx_full, rx_empty;
    logic           tx_push, tx_pop, rx_push, rx_pop, tx_idle;

    logic [2:0]    tx_state, rx_state;
    logic [DW-1:0] tx_cnt, rx_cnt;
    logic [2:0]    tx_bit, rx_bit;
    logic [7:0]    tx_sh, rx_sh;
    logic          tx_par, tx_stop2;
    logic          rx_stop_tick, ferr_set, perr_set;

`ifdef UART_PARITY_EN
    localparam logic [7:0] CTRL_MASK = 8'hFF;
    assign par_en  = (ctrl[2:1] == 2'b01) || (ctrl[2:1] == 2'b10);
    assign par_odd = (ctrl[2:1] == 2'b10);
`else
    localparam logic [7:0] CTRL_MASK = 8'hF9;
    assign par_en  = 1'b0;
    assign par_odd = 1'b0;
`endif

    assign wr         = (data_write_n != 2'b11);
    assign rd         = (data_read_n != 2'b11);
    assign data_ready = 1'b1;

    assign div_eff  = (divider < DW'(2)) ? DW'(2) : divider;
    assign bit_len  = div_eff - DW'(1);
    assign half_len = (div_eff >> 1) - DW'(1);
    assign rx_thr   = (ctrl[7:4] == 4'd0) ? 4'd1 : ctrl[7:4];
    assign rxd      = ctrl[0] ? ui_in[3] : ui_in[7];

    assign tx_push = wr && (address == 6'h0);
    assign tx_pop  = (tx_state == S_IDLE) && !tx_empty;
    assign rx_pop  = rd && (address == 6'h0) && !rx_empty;
    assign tx_idle = tx_empty && (tx_state == S_IDLE);

    assign rx_stop_tick = (rx_state == S_STOP) && (rx_cnt == '0);
    assign rx_push      = rx_stop_tick && rxd;
    assign ferr_set     = rx_stop_tick && !rxd;
    assign perr_set     = par_en && (rx_state == S_PARITY) && (rx_cnt == '0)
                          && (rxd != (^rx_sh ^ par_odd));

    // Flag order matches status bits [6:3]: TXOVF, FERR, PERR, RXOVR
    assign flag_set = {tx_push && tx_full && !tx_pop, ferr_set, perr_set,
                       rx_push && rx_full && !rx_pop};
    assign flag_clr = (wr && address == 6'h4) ? data_in[6:3] : 4'd0;

    assign rts            = (8'(rx_level) >= 8'(RX_DEPTH - 1));
    assign uo_out         = {4{rts, txd}};
    assign user_interrupt = {!tx_full, 8'(rx_level) >= {4'd0, rx_thr}};

    tqvp_uart_fifo_q #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .push_data(data_in[7:0]), .pop(tx_pop),
        .head(tx_head), .level(tx_level), .full(tx_full), .empty(tx_empty)
    );

    tqvp_uart_fifo_q #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .push_data(rx_sh), .pop(rx_pop),
        .head(rx_head), .level(rx_level), .full(rx_full), .empty(rx_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            divider <= DIV_RESET;
            ctrl    <= 8'd0;
            flags   <= 4'd0;
        end else begin
            if (wr && address == 6'h8)
                divider <= (data_write_n == 2'b00) ? {divider[DW-1:8], data_in[7:0]}
                                                   : data_in[DW-1:0];
            if (wr && address == 6'hC)
                ctrl <= data_in[7:0] & CTRL_MASK;
            flags <= (flags & ~flag_clr) | flag_set;
        end
    end

    always_comb begin
        case (tx_state)
            S_START:  txd = 1'b0;
            S_DATA:   txd = tx_sh[0];
            S_PARITY: txd = tx_par;
            default:  txd = 1'b1;
        endcase
    end

    // Counters reload at every bit boundary, so divider changes apply from the next bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx_sh    <= 8'd0;
            tx_par   <= 1'b0;
            tx_stop2 <= 1'b0;
        end else if (tx_state == S_IDLE) begin
            if (!tx_empty) begin
                tx_state <= S_START;
                tx_cnt   <= bit_len;
                tx_bit   <= 3'd0;
                tx_sh    <= tx_head;
                tx_par   <= ^tx_head ^ par_odd;
                tx_stop2 <= 1'b0;
            end
        end else if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - DW'(1);
        end else begin
            tx_cnt <= bit_len;
            case (tx_state)
                S_START:  tx_state <= S_DATA;
                S_DATA: begin
                    tx_sh  <= tx_sh >> 1;
                    tx_bit <= tx_bit + 3'd1;
                    if (tx_bit == 3'd7)
                        tx_state <= par_en ? S_PARITY : S_STOP;
                end
                S_PARITY: tx_state <= S_STOP;
                default: begin
                    if (ctrl[3] && !tx_stop2)
                        tx_stop2 <= 1'b1;
                    else
                        tx_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_sh    <= 8'd0;
            rxd_q    <= 1'b1;
        end else begin
            rxd_q <= rxd;
            if (rx_state == S_IDLE) begin
                if (rxd_q && !rxd) begin
                    rx_state <= S_START;
                    rx_cnt   <= half_len;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - DW'(1);
            end else begin
                rx_cnt <= bit_len;
                case (rx_state)
                    S_START: begin
                        rx_state <= rxd ? S_IDLE : S_DATA;
                        rx_bit   <= 3'd0;
                    end
                    S_DATA: begin
                        rx_sh  <= {rxd, rx_sh[7:1]};
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7)
                            rx_state <= par_en ? S_PARITY : S_STOP;
                    end
                    S_PARITY: rx_state <= S_STOP;
                    default:  rx_state <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        case (address)
            6'h0:    data_out = {24'd0, rx_empty ? 8'd0 : rx_head};
            6'h4:    data_out = {8'd0, 8'(tx_level), 8'(rx_level), 1'b0, flags,
                                 tx_idle, !rx_empty, tx_full};
            6'h8:    data_out = 32'(divider);
            6'hC:    data_out = {24'd0, ctrl};
            default: data_out = 32'd0;
        endcase
    end

    logic unused_in;
    assign unused_in = ^{data_in[31:DW], ui_in[6:4], ui_in[2:0]};
endmodule

// File: tb/tb_tqvp_uart_fifo.sv
// tb/tb_tqvp_uart_fifo.sv - directed self-checking bench for tqvp_uart_fifo

module tb_tqvp_uart_fifo;
    logic        clk;
    logic        rst_n;
    logic        rxd_line;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic [1:0]  user_interrupt;

    int n_checks = 0;
    int n_pass   = 0;
    int tx_bad_stop = 0;
    logic [7:0]  tx_seen[$];
    logic [7:0]  mon_byte;
    logic [31:0] rdata, rdata2;

    assign ui_in = {rxd_line, 7'h7F};

    tqvp_uart_fifo dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
        .address(address), .data_in(data_in), .data_write_n(data_write_n),
        .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
        .user_interrupt(user_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
        @(negedge clk);
        address = a; data_in = d; data_write_n = wn;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; data_read_n = 2'b10;
        #1 d = data_out;
        @(negedge clk);
        data_read_n = 2'b11;
    endtask

    // Divider 8: start, 8 data LSB first, optional parity, one stop, then idle high
    task automatic rx_send(input logic [7:0] b, input logic with_par, input logic par_bit,
                           input logic stop_bit);
        @(negedge clk);
        rxd_line = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_line = b[i];
            repeat (8) @(negedge clk);
        end
        if (with_par) begin
            rxd_line = par_bit;
            repeat (8) @(negedge clk);
        end
        rxd_line = stop_bit;
        repeat (8) @(negedge clk);
        rxd_line = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_tx(input int n);
        for (int k = 0; k < 3000 && tx_seen.size() < n; k++)
            @(negedge clk);
        check("tx_frame_count", 32'(tx_seen.size()), 32'(n));
    endtask

    // Decodes txd frames at divider 8, sampling mid-bit
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && uo_out[0] == 1'b0) begin
                repeat (4) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (8) @(negedge clk);
                    mon_byte[i] = uo_out[0];
                end
                repeat (8) @(negedge clk);
                if (uo_out[0] !== 1'b1)
                    tx_bad_stop++;
                tx_seen.push_back(mon_byte);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rxd_line = 1'b1; address = 6'h0; data_in = 32'd0;
        data_write_n = 2'b11; data_read_n = 2'b11;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_uo_out", 32'(uo_out), 32'h55);
        check("rst_irq", 32'(user_interrupt), 32'h2);
        check("data_ready", 32'(data_ready), 32'h1);
        bus_read(6'h4, rdata);  check("rst_status", rdata, 32'h4);
        bus_read(6'h8, rdata);  check("rst_divider", rdata, 32'd555);
        bus_read(6'hC, rdata);  check("rst_ctrl", rdata, 32'h0);
        bus_read(6'h10, rdata); check("unmapped_read", rdata, 32'h0);
        bus_read(6'h0, rdata);  check("empty_rx_read", rdata, 32'h0);

        bus_write(6'h8, 32'h0000_0305, 2'b10); bus_read(6'h8, rdata); check("div_w32", rdata, 32'h305);
        bus_write(6'h8, 32'hFFFF_FF08, 2'b00); bus_read(6'h8, rdata); check("div_w8", rdata, 32'h308);
        bus_write(6'h8, 32'h0000_0008, 2'b01); bus_read(6'h8, rdata); check("div_w16", rdata, 32'h8);

        bus_write(6'h0, 32'h41, 2'b00);
        check("tx_pre_start", 32'(uo_out[0]), 32'h1);
        @(negedge clk); check("tx_start_latency", 32'(uo_out[0]), 32'h0);
        repeat (7) @(negedge clk); check("tx_start_end", 32'(uo_out[0]), 32'h0);
        @(negedge clk); check("tx_bit0", 32'(uo_out[0]), 32'h1);
        wait_tx(1);
        check("tx_byte_41", tx_seen.size() > 0 ? 32'(tx_seen[0]) : 32'hFFFF, 32'h41);
        repeat (10) @(negedge clk);
        bus_read(6'h4, rdata); check("tx_idle_after", rdata, 32'h4);

        for (int i = 1; i <= 6; i++)
            bus_write(6'h0, 32'h10 + 32'(i), 2'b00);
        bus_read(6'h4, rdata); check("txovf_status", rdata, 32'h0004_0041);
        check("txovf_irq", 32'(user_interrupt), 32'h0);
        wait_tx(6);
        repeat (200) @(negedge clk);
        check("tx_sixth_dropped", 32'(tx_seen.size()), 32'd6);
        for (int i = 1; i < 6; i++)
            check("tx_queued_byte", tx_seen.size() > i ? 32'(tx_seen[i]) : 32'hFFFF, 32'h10 + 32'(i));
        check("tx_stop_bits", 32'(tx_bad_stop), 32'd0);
        bus_write(6'h4, 32'h40, 2'b10);
        bus_read(6'h4, rdata); check("txovf_clear", rdata, 32'h4);

`ifdef UART_PARITY_EN
        bus_write(6'hC, 32'h2A, 2'b00); bus_read(6'hC, rdata); check("ctrl_w8", rdata, 32'h2A);
`else
        bus_write(6'hC, 32'h2A, 2'b00); bus_read(6'hC, rdata); check("ctrl_w8_nopar", rdata, 32'h28);
`endif
        bus_write(6'hC, 32'hFFFF_FF20, 2'b10); bus_read(6'hC, rdata); check("ctrl_w32", rdata, 32'h20);

        rx_send(8'h5A, 1'b0, 1'b0, 1'b1);
        bus_read(6'h4, rdata); check("rx_one_status", rdata, 32'h0000_0106);
        check("rx_irq_below_thr", 32'(user_interrupt), 32'h2);
        rx_send(8'hC3, 1'b0, 1'b0, 1'b1);
        check("rx_irq_at_thr", 32'(user_interrupt), 32'h3);
        @(negedge clk);
        address = 6'h0; data_read_n = 2'b10;
        #1 rdata = data_out;
        @(negedge clk);
        #1 rdata2 = data_out;
        @(negedge clk);
        data_read_n = 2'b11;
        check("rx_read_5a", rdata, 32'h5A);
        check("rx_read_c3_b2b", rdata2, 32'hC3);
        bus_read(6'h0, rdata); check("rx_read_empty", rdata, 32'h0);
        check("rx_irq_cleared", 32'(user_interrupt), 32'h2);

`ifdef UART_PARITY_EN
        bus_write(6'hC, 32'h22, 2'b00);
        rx_send(8'h01, 1'b1, 1'b0, 1'b1);
        bus_read(6'h4, rdata); check("perr_status", rdata, 32'h0000_0116);
        bus_read(6'h0, rdata); check("perr_byte", rdata, 32'h01);
        bus_write(6'h4, 32'h10, 2'b00);
        bus_read(6'h4, rdata); check("perr_clear", rdata, 32'h4);
`else
        bus_write(6'hC, 32'h22, 2'b00);
        bus_read(6'hC, rdata); check("ctrl_parity_ignored", rdata, 32'h20);
        rx_send(8'h01, 1'b0, 1'b0, 1'b1);
        bus_read(6'h4, rdata); check("noperr_status", rdata, 32'h0000_0106);
        bus_read(6'h0, rdata); check("noperr_byte", rdata, 32'h01);
`endif

        bus_write(6'hC, 32'h00, 2'b00);
        rx_send(8'h77, 1'b0, 1'b0, 1'b0);
        bus_read(6'h4, rdata); check("ferr_status", rdata, 32'h24);
        bus_write(6'h4, 32'h20, 2'b10);
        bus_read(6'h4, rdata); check("ferr_clear", rdata, 32'h4);

        for (int i = 0; i < 5; i++) begin
            rx_send(8'hA0 + 8'(i), 1'b0, 1'b0, 1'b1);
            if (i == 1) check("rts_two_held", 32'(uo_out[7]), 32'h0);
            if (i == 2) check("rts_three_held", 32'(uo_out[7]), 32'h1);
        end
        bus_read(6'h4, rdata); check("rxovr_status", rdata, 32'h0000_040E);
        check("rx_irq_thr0", 32'(user_interrupt), 32'h3);
        for (int i = 0; i < 4; i++) begin
            bus_read(6'h0, rdata);
            check("rx_ovf_readback", rdata, 32'hA0 + 32'(i));
        end
        bus_read(6'h0, rdata); check("rx_ovf_drained", rdata, 32'h0);
        check("rts_released", 32'(uo_out[7]), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
